// File: rtl/clk_gate_pkg.sv
// Shared types and width helpers for the clk_gate_ctrl idle-driven clock-gating controller.
package clk_gate_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        SLP_REQ = 2'd1,
        GATED   = 2'd2,
        WAKE    = 2'd3
    } gate_state_e;

    // Counter width for a counter that runs 0..n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int IDLE_CYCLES_DEF = 16;
    localparam int WAKE_CYCLES_DEF = 2;
    localparam int IDLE_W_DEF      = cnt_width(IDLE_CYCLES_DEF);
    localparam int WAKE_W_DEF      = cnt_width(WAKE_CYCLES_DEF);

endpackage

// File: rtl/clk_icg.sv
// Latch-based integrated clock gate: the enable is captured while clk_i is low so clk_o never glitches.
module clk_icg (
    input  logic clk_i,
    input  logic en_i,
    input  logic te_i,
    output logic clk_o
);

    logic en_latched;

    always_latch begin
        if (!clk_i) begin
            en_latched <= en_i | te_i;
        end
    end

    assign clk_o = clk_i & en_latched;

endmodule

// File: rtl/clk_gate_ctrl.sv
// Idle-driven clock-gating controller with sleep request/ack handshake.
// Statistics counters are built only when CLK_GATE_CTRL_STAT_EN is defined.
module clk_gate_ctrl
    import clk_gate_pkg::*;
#(
    parameter int IDLE_CYCLES = 16,
    parameter int WAKE_CYCLES = 2,
    parameter int STAT_WIDTH  = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  te_i,
    input  logic                  busy_i,
    input  logic                  wake_i,
    input  logic                  force_on_i,
    input  logic                  slp_ack_i,
    input  logic                  clr_stat_i,
    output logic                  slp_req_o,
    output logic                  clk_en_o,
    output logic                  clk_o,
    output logic                  gated_o,
    output logic                  wake_done_o,
    output logic [STAT_WIDTH-1:0] gate_cnt_o,
    output logic [STAT_WIDTH-1:0] gate_evt_o
);

    localparam int IDLE_W = cnt_width(IDLE_CYCLES);
    localparam int WAKE_W = cnt_width(WAKE_CYCLES);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_CYCLES - 1);
    localparam logic [WAKE_W-1:0] WAKE_LAST = WAKE_W'(WAKE_CYCLES - 1);

    generate
        if (IDLE_CYCLES < 1 || WAKE_CYCLES < 1 || STAT_WIDTH < 1) begin : g_param_err
            $error("clk_gate_ctrl: IDLE_CYCLES, WAKE_CYCLES and STAT_WIDTH must all be >= 1");
        end
    endgenerate

    gate_state_e       state_q, state_d;
    logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
    logic [WAKE_W-1:0] wake_cnt_q, wake_cnt_d;
    logic              slp_req_q, slp_req_d;
    logic              clk_en_q, clk_en_d;
    logic              gated_q, gated_d;
    logic              wake_done_q, wake_done_d;
    logic              act;

    // Counters default to zero so any state change clears them.
    always_comb begin
        act        = busy_i | wake_i | force_on_i;
        state_d    = state_q;
        idle_cnt_d = '0;
        wake_cnt_d = '0;
        case (state_q)
            RUN: begin
                if (!act) begin
                    if (idle_cnt_q == IDLE_LAST) state_d = SLP_REQ;
                    else                         idle_cnt_d = idle_cnt_q + 1'b1;
                end
            end
            SLP_REQ: begin
                if (act)            state_d = RUN;
                else if (slp_ack_i) state_d = GATED;
            end
            GATED: begin
                if (act) state_d = WAKE;
            end
            WAKE: begin
                if (wake_cnt_q == WAKE_LAST) state_d = RUN;
                else                         wake_cnt_d = wake_cnt_q + 1'b1;
            end
            default: state_d = RUN;
        endcase
        slp_req_d   = (state_d != RUN);
        clk_en_d    = (state_d != GATED);
        gated_d     = (state_d == GATED);
        wake_done_d = (state_q == WAKE) && (state_d == RUN);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= RUN;
            idle_cnt_q  <= '0;
            wake_cnt_q  <= '0;
            slp_req_q   <= 1'b0;
            clk_en_q    <= 1'b1;
            gated_q     <= 1'b0;
            wake_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idle_cnt_q  <= idle_cnt_d;
            wake_cnt_q  <= wake_cnt_d;
            slp_req_q   <= slp_req_d;
            clk_en_q    <= clk_en_d;
            gated_q     <= gated_d;
            wake_done_q <= wake_done_d;
        end
    end

    assign slp_req_o   = slp_req_q;
    assign clk_en_o    = clk_en_q;
    assign gated_o     = gated_q;
    assign wake_done_o = wake_done_q;

`ifdef CLK_GATE_CTRL_STAT_EN
    logic [STAT_WIDTH-1:0] gate_cnt_q, gate_cnt_d;
    logic [STAT_WIDTH-1:0] gate_evt_q, gate_evt_d;

    // Saturating counters; a clear beats a same-cycle increment.
    always_comb begin
        gate_cnt_d = gate_cnt_q;
        gate_evt_d = gate_evt_q;
        if (clr_stat_i) begin
            gate_cnt_d = '0;
            gate_evt_d = '0;
        end else begin
            if (state_q == GATED && gate_cnt_q != '1) gate_cnt_d = gate_cnt_q + 1'b1;
            if (state_q == SLP_REQ && state_d == GATED && gate_evt_q != '1) gate_evt_d = gate_evt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            gate_cnt_q <= '0;
            gate_evt_q <= '0;
        end else begin
            gate_cnt_q <= gate_cnt_d;
            gate_evt_q <= gate_evt_d;
        end
    end

    assign gate_cnt_o = gate_cnt_q;
    assign gate_evt_o = gate_evt_q;
`else
    logic unused_clr_stat;
    assign unused_clr_stat = clr_stat_i;
    assign gate_cnt_o      = '0;
    assign gate_evt_o      = '0;
`endif

    clk_icg u_icg (
        .clk_i (clk_i),
        .en_i  (clk_en_q),
        .te_i  (te_i),
        .clk_o (clk_o)
    );

endmodule
